// File: rtl/adc_avg_filter_pkg.sv
// Shared constants for the ADC conditioning slice: default widths, sample-rate
// divider default and the averaging FSM state encoding.
package adc_avg_filter_pkg;

    localparam int ADC_BITWIDTH_DEF = 4;

    // 1000 enable pulses per sample slot gives 1 kHz sampling at a 1 MHz enable.
    localparam int SAMPLE_DIV_DEF = 1000;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/adc_avg_filter_if.sv
// Bus bundle between the ADC filter and its neighbours: enable, raw ADC in,
// filtered value out with valid/reject pulses.
interface adc_avg_filter_if
    import adc_avg_filter_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF
) ();

    logic                    clk_en_i;
    logic [ADC_BITWIDTH-1:0] ADC_value_i;
    logic [ADC_BITWIDTH-1:0] ADC_value_o;
    logic                    valid_o;
    logic                    reject_o;

    modport master (
        output clk_en_i,
        output ADC_value_i,
        input  ADC_value_o,
        input  valid_o,
        input  reject_o
    );

    modport slave (
        input  clk_en_i,
        input  ADC_value_i,
        output ADC_value_o,
        output valid_o,
        output reject_o
    );

endinterface

// File: rtl/adc_sample_divider.sv
// Enable-gated modulo-SAMPLE_DIV counter producing a single-cycle sample tick;
// also usable as the controller timestep generator.
module adc_sample_divider
    import adc_avg_filter_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clk_en_i,
    output logic tick_o
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;

    assign tick_o = clk_en_i && (cnt_reg == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg <= '0;
        end else if (clk_en_i) begin
            cnt_reg <= tick_o ? '0 : cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Synchronise, decimate, stability-check and moving-average the pad ADC bus.
// Define ADC_AVG_HYST_EN to suppress output changes smaller than 2 LSB.
module adc_avg_filter
    import adc_avg_filter_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
    parameter int AVG_LOG2     = 2,
    parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF
) (
    input logic             clk_i,
    input logic             rstn_i,
    adc_avg_filter_if.slave bus
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_BITWIDTH + AVG_LOG2;

    logic [ADC_BITWIDTH-1:0] sync1_reg, sync2_reg, sync3_reg;
    logic                    tick;
    logic [ADC_BITWIDTH-1:0] sample_reg;
    logic                    accept_reg;
    logic                    pend_reg;
    logic [0:0]              state_reg;
    logic [AVG_LOG2-1:0]     ptr_reg;
    logic [SUM_W-1:0]        sum_reg;
    logic [SUM_W-1:0]        sum_next;
    logic [ADC_BITWIDTH-1:0] buf_reg [DEPTH];
    logic [ADC_BITWIDTH-1:0] avg_next;
    logic [ADC_BITWIDTH-1:0] out_reg;
    logic                    valid_reg;
    logic                    reject_reg;
    logic                    acc_fire;
    logic                    do_update;

    adc_sample_divider #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_div (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clk_en_i (bus.clk_en_i),
        .tick_o   (tick)
    );

    assign acc_fire = pend_reg && accept_reg;

    // The running sum always equals the sum of the buffer, so the subtraction never wraps.
    always_comb begin
        sum_next = sum_reg;
        if (state_reg == ST_INIT) begin
            sum_next = SUM_W'(sample_reg) << AVG_LOG2;
        end else begin
            sum_next = sum_reg + SUM_W'(sample_reg) - SUM_W'(buf_reg[ptr_reg]);
        end
    end

    assign avg_next = sum_next[SUM_W-1:AVG_LOG2];

`ifdef ADC_AVG_HYST_EN
    logic [ADC_BITWIDTH-1:0] diff;
    assign diff      = (avg_next > out_reg) ? (avg_next - out_reg) : (out_reg - avg_next);
    // Rails and the first post-INIT value always pass so the output can reach the extremes.
    assign do_update = (state_reg == ST_INIT) || (diff >= ADC_BITWIDTH'(2))
                    || (avg_next == '0) || (avg_next == {ADC_BITWIDTH{1'b1}});
`else
    assign do_update = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            sync3_reg  <= '0;
            sample_reg <= '0;
            accept_reg <= 1'b0;
            pend_reg   <= 1'b0;
            state_reg  <= ST_INIT;
            ptr_reg    <= '0;
            sum_reg    <= '0;
            out_reg    <= '0;
            valid_reg  <= 1'b0;
            reject_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            sync1_reg  <= bus.ADC_value_i;
            sync2_reg  <= sync1_reg;
            sync3_reg  <= sync2_reg;
            pend_reg   <= tick;
            reject_reg <= tick && (sync2_reg != sync3_reg);
            valid_reg  <= acc_fire;
            if (tick) begin
                sample_reg <= sync2_reg;
                accept_reg <= (sync2_reg == sync3_reg);
            end
            if (acc_fire) begin
                sum_reg <= sum_next;
                if (state_reg == ST_INIT) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        buf_reg[i] <= sample_reg;
                    end
                    ptr_reg   <= '0;
                    state_reg <= ST_RUN;
                end else begin
                    buf_reg[ptr_reg] <= sample_reg;
                    ptr_reg          <= ptr_reg + AVG_LOG2'(1);
                end
                if (do_update) begin
                    out_reg <= avg_next;
                end
            end
        end
    end

    assign bus.ADC_value_o = out_reg;
    assign bus.valid_o     = valid_reg;
    assign bus.reject_o    = reject_reg;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Scoreboard bench for adc_avg_filter: slot-level stimulus, window-average model,
// event checks on valid/reject timing and value.
module tb_adc_avg_filter;
    localparam int W   = 4;
    localparam int L   = 2;
    localparam int N   = 1 << L;
    localparam int DIV = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_avg_filter_if #(.ADC_BITWIDTH(W)) bus ();

    adc_avg_filter #(
        .ADC_BITWIDTH (W),
        .AVG_LOG2     (L),
        .SAMPLE_DIV   (DIV)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    typedef struct {
        bit           is_rej;
        logic [W-1:0] val;
        int           at;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           rej_cnt = 0;
    int           last_valid_cyc = 0;
    int           prev_valid_cyc = 0;
    int           win_q[$];
    logic [W-1:0] mdl_out = '0;
    bit           mdl_init = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: explicit list of the last N accepted samples.
    task automatic model_accept(input logic [W-1:0] v, output logic [W-1:0] res);
        int s;
        int avg;
        bit upd;
        bit first;
        first = mdl_init;
        if (mdl_init) begin
            win_q.delete();
            for (int i = 0; i < N; i++) win_q.push_back(int'(v));
            mdl_init = 1'b0;
        end else begin
            win_q.push_back(int'(v));
            void'(win_q.pop_front());
        end
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        avg = s / N;
        upd = 1'b1;
`ifdef ADC_AVG_HYST_EN
        upd = first || (avg - int'(mdl_out) >= 2) || (int'(mdl_out) - avg >= 2)
              || (avg == 0) || (avg == (1 << W) - 1);
`endif
        if (first) upd = 1'b1;
        if (upd) mdl_out = avg[W-1:0];
        res = mdl_out;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event: no output at cycle %0d (now %0d), required rej=%0b val=%0d",
                         exp_q[0].at, cyc, exp_q[0].is_rej, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (bus.valid_o || bus.reject_o) begin
                n_cmp++;
                if (bus.reject_o) rej_cnt++;
                if (bus.valid_o) begin
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: cycle %0d valid=%0b reject=%0b value=%0d, required none",
                             cyc, bus.valid_o, bus.reject_o, bus.ADC_value_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.reject_o !== mon_e.is_rej || bus.valid_o !== !mon_e.is_rej
                        || bus.ADC_value_o !== mon_e.val || cyc != mon_e.at) begin
                        n_bad++;
                        $display("FAIL event: got cyc=%0d valid=%0b reject=%0b value=%0d, required cyc=%0d reject=%0b value=%0d",
                                 cyc, bus.valid_o, bus.reject_o, bus.ADC_value_o, mon_e.at, mon_e.is_rej, mon_e.val);
                    end else begin
                        $display("event: cyc=%0d %s value=%0d", cyc, mon_e.is_rej ? "reject" : "valid",
                                 bus.ADC_value_o);
                    end
                end
            end
        end
    end

    // One sample slot of DIV enabled cycles; the last edge of the slot is the tick.
    task automatic run_slot(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                            input int period);
        int   last_e;
        exp_t e;
        last_e = DIV * period;
        bus.ADC_value_i = a;
        for (int k = 1; k <= last_e; k++) begin
            bus.clk_en_i = (k % period) == 0;
            @(posedge clk);
            #1;
            if (toggle && k == last_e - 3) bus.ADC_value_i = b;
        end
        if (toggle) begin
            e.is_rej = 1'b1;
            e.val    = mdl_out;
            e.at     = cyc;
        end else begin
            e.is_rej = 1'b0;
            model_accept(a, e.val);
            e.at     = cyc + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        bus.clk_en_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.clk_en_i    = 1'b0;
        bus.ADC_value_i = '0;
        rstn = 1'b0;
        exp_q.delete();
        mdl_init = 1'b1;
        mdl_out  = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.ADC_value_o !== '0 || bus.valid_o !== 1'b0 || bus.reject_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got value=%0d valid=%0b reject=%0b, required 0/0/0",
                     bus.ADC_value_o, bus.valid_o, bus.reject_o);
        end
        release_reset();
        idle(2);
        n_cmp++;
        if (bus.ADC_value_o !== '0 || bus.valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL after_release: got value=%0d valid=%0b, required 0/0", bus.ADC_value_o, bus.valid_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_first_sample();
        int r0;
        r0 = rej_cnt;
        run_slot(4'd9, 4'd9, 1'b0, 1);
        run_slot(4'd9, 4'd9, 1'b0, 1);
        idle(4);
        n_cmp++;
        if (bus.ADC_value_o !== 4'd9 || rej_cnt != r0) begin
            n_bad++;
            $display("FAIL first_sample: got value=%0d rejects=%0d, required value=9 rejects=0",
                     bus.ADC_value_o, rej_cnt - r0);
        end
    endtask

    task automatic test_step();
        for (int i = 0; i < 4; i++) run_slot(4'd4, 4'd4, 1'b0, 1);
        for (int i = 0; i < 5; i++) run_slot(4'd12, 4'd12, 1'b0, 1);
        idle(4);
        n_cmp++;
        if (bus.ADC_value_o !== 4'd12) begin
            n_bad++;
            $display("FAIL step_final: got %0d, required 12", bus.ADC_value_o);
        end
    endtask

    task automatic test_reject();
        int r0;
        r0 = rej_cnt;
        run_slot(4'd3, 4'd5, 1'b1, 1);
        run_slot(4'd5, 4'd3, 1'b1, 1);
        idle(4);
        n_cmp++;
        if (rej_cnt - r0 != 2 || bus.ADC_value_o !== 4'd12) begin
            n_bad++;
            $display("FAIL reject: got rejects=%0d value=%0d, required rejects=2 value=12",
                     rej_cnt - r0, bus.ADC_value_o);
        end
    endtask

    task automatic test_reset_mid();
        run_slot(4'd15, 4'd15, 1'b0, 1);
        run_slot(4'd15, 4'd15, 1'b0, 1);
        idle(4);
        run_slot(4'd15, 4'd15, 1'b0, 1);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.ADC_value_o !== '0 || bus.valid_o !== 1'b0 || bus.reject_o !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got value=%0d valid=%0b reject=%0b, required 0/0/0",
                     bus.ADC_value_o, bus.valid_o, bus.reject_o);
        end
        apply_reset();
        release_reset();
        run_slot(4'd7, 4'd7, 1'b0, 1);
        idle(4);
        n_cmp++;
        if (bus.ADC_value_o !== 4'd7) begin
            n_bad++;
            $display("FAIL refill_after_reset: got %0d, required 7", bus.ADC_value_o);
        end
    endtask

    task automatic test_duty();
        for (int i = 0; i < 3; i++) run_slot(4'd6, 4'd6, 1'b0, 3);
        idle(4);
        n_cmp++;
        if (last_valid_cyc - prev_valid_cyc != 12) begin
            n_bad++;
            $display("FAIL valid_period: got %0d cycles, required 12", last_valid_cyc - prev_valid_cyc);
        end
    endtask

    task automatic test_hyst();
        logic [W-1:0] want;
        apply_reset();
        release_reset();
        run_slot(4'd8, 4'd8, 1'b0, 1);
        for (int i = 0; i < 5; i++) run_slot(4'd9, 4'd9, 1'b0, 1);
        idle(4);
`ifdef ADC_AVG_HYST_EN
        want = 4'd8;
`else
        want = 4'd9;
`endif
        n_cmp++;
        if (bus.ADC_value_o !== want) begin
            n_bad++;
            $display("FAIL hyst_hold: got %0d, required %0d", bus.ADC_value_o, want);
        end
        for (int i = 0; i < 4; i++) run_slot(4'd0, 4'd0, 1'b0, 1);
        idle(4);
        n_cmp++;
        if (bus.ADC_value_o !== 4'd0) begin
            n_bad++;
            $display("FAIL hyst_zero: got %0d, required 0", bus.ADC_value_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clk_en_i    = 1'b0;
        bus.ADC_value_i = '0;
        test_reset();
        test_first_sample();
        test_step();
        test_reject();
        test_reset_mid();
        test_duty();
        test_hyst();
        idle(6);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
